// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the arbitrated 4x4 multiplier:
//   - operand / product / requester-index widths
//   - FSM state encoding used by mult_arbiter
//   - ring-increment helper for the round-robin pointer
// -----------------------------------------------------------------------------
package mult_pkg;

   // Operand width of each multiplicand / multiplier.
   localparam int OPND_W = 4;

   // Full-width unsigned product; never truncated.
   localparam int PROD_W = 2 * OPND_W;

   // Width of a requester index (supports up to 8 requesters).
   localparam int ID_W = 3;

   // Width of the completed-response counter.
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Next index after idx on a ring of n entries (n-1 wraps to 0).
   function automatic logic [ID_W-1:0] ring_inc(input logic [ID_W-1:0] idx,
                                                input int              n);
      logic [ID_W-1:0] nxt;
      if (int'(idx) >= (n - 1)) begin
         nxt = '0;
      end else begin
         nxt = idx + 1'b1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/multiplier_4x4.sv
// -----------------------------------------------------------------------------
// multiplier_4x4
// Purely combinational unsigned 4x4 multiplier.
// Ports:
//   A : input  [3:0]  multiplicand
//   B : input  [3:0]  multiplier
//   P : output [7:0]  full unsigned product A*B
// -----------------------------------------------------------------------------
module multiplier_4x4
   import mult_pkg::*;
(
   input  logic [OPND_W-1:0] A,
   input  logic [OPND_W-1:0] B,
   output logic [PROD_W-1:0] P
);

   // Widen both operands first so the product is evaluated at full width.
   assign P = PROD_W'(A) * PROD_W'(B);

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// N_REQ requesters share one 4x4 multiplier. A round-robin arbiter grants one
// requester while idle, its operands are captured, the product is registered
// one cycle later and then presented with a valid/ready handshake. Only one
// operation is ever in flight.
// Ports:
//   clk        : input              rising-edge clock
//   rst        : input              synchronous active-high reset
//   req_valid  : input  [N_REQ-1:0] per-requester request
//   req_a      : input  [4*N_REQ-1:0] multiplicands, requester i at [4i+3:4i]
//   req_b      : input  [4*N_REQ-1:0] multipliers,   requester i at [4i+3:4i]
//   req_ready  : output [N_REQ-1:0] one-hot grant (combinational, IDLE only)
//   rsp_valid  : output             result available (RESP state)
//   rsp_p      : output [7:0]       unsigned product
//   rsp_id     : output [2:0]       owner of rsp_p
//   rsp_ready  : input              consumer accepts the result
//   op_count   : output [7:0]       completed responses, wraps 255->0
// -----------------------------------------------------------------------------
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int N_REQ = 4
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [OPND_W*N_REQ-1:0] req_a,
   input  logic [OPND_W*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    rsp_valid,
   output logic [PROD_W-1:0]       rsp_p,
   output logic [ID_W-1:0]         rsp_id,
   input  logic                    rsp_ready,
   output logic [CNT_W-1:0]        op_count
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_next;
   logic [ID_W-1:0]     r_ptr;
   logic [OPND_W-1:0]   r_a_q;
   logic [OPND_W-1:0]   r_b_q;
   logic [ID_W-1:0]     r_id_q;
   logic [PROD_W-1:0]   r_rsp_p;
   logic [ID_W-1:0]     r_rsp_id;
   logic [CNT_W-1:0]    r_op_count;

   // ---------------------------------------------------------------------
   // Arbitration signals
   // ---------------------------------------------------------------------
   logic [ID_W-1:0]     w_rot_idx [N_REQ];
   logic [N_REQ-1:0]    w_rot_valid;
   logic [OPND_W-1:0]   w_a_arr   [N_REQ];
   logic [OPND_W-1:0]   w_b_arr   [N_REQ];
   logic                w_found;
   logic [ID_W-1:0]     w_win_idx;
   logic [N_REQ-1:0]    w_grant_vec;
   logic [OPND_W-1:0]   w_win_a;
   logic [OPND_W-1:0]   w_win_b;
   logic                w_take;
   logic                w_done;
   logic [PROD_W-1:0]   w_prod;

   // ---------------------------------------------------------------------
   // Rotated view of the request vector: slot gi holds requester
   // (ptr + gi) mod N_REQ, so the first valid slot is the round-robin winner.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_rot
         localparam logic [ID_W:0] OFFS = (ID_W+1)'(gi);
         localparam logic [ID_W:0] NREQ = (ID_W+1)'(N_REQ);
         logic [ID_W:0] w_sum;

         assign w_sum = {1'b0, r_ptr} + OFFS;
         assign w_rot_idx[gi] = (w_sum >= NREQ) ? ID_W'(w_sum - NREQ)
                                                : w_sum[ID_W-1:0];
         // Shift-and-mask lookup keeps the index width independent of N_REQ.
         assign w_rot_valid[gi] = |(req_valid & (N_REQ'(1) << w_rot_idx[gi]));

         // Operand unpacking, requester gi
         assign w_a_arr[gi] = req_a[gi*OPND_W +: OPND_W];
         assign w_b_arr[gi] = req_b[gi*OPND_W +: OPND_W];
      end
   endgenerate

   // Priority pick over the rotated slots.
   always_comb begin
      w_found   = 1'b0;
      w_win_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && w_rot_valid[k]) begin
            w_found   = 1'b1;
            w_win_idx = w_rot_idx[k];
         end
      end
      w_grant_vec = w_found ? (N_REQ'(1) << w_win_idx) : '0;
   end

   // Winner's operands.
   always_comb begin
      w_win_a = '0;
      w_win_b = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (ID_W'(k) == w_win_idx) begin
            w_win_a = w_a_arr[k];
            w_win_b = w_b_arr[k];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Shared multiplier; its inputs are the captured operands only, so later
   // req_* activity cannot disturb an accepted operation.
   // ---------------------------------------------------------------------
   multiplier_4x4 u_mult (
      .A (r_a_q),
      .B (r_b_q),
      .P (w_prod)
   );

   // ---------------------------------------------------------------------
   // FSM next-state / outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      req_ready    = '0;
      w_take       = 1'b0;
      w_done       = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               req_ready    = w_grant_vec;
               w_take       = 1'b1;
               w_state_next = CALC;
            end
         end
         CALC: begin
            w_state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               w_done       = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      // Reset wins: no grant is visible and nothing completes in this cycle.
      if (rst) begin
         req_ready    = '0;
         w_take       = 1'b0;
         w_done       = 1'b0;
         w_state_next = IDLE;
      end
   end

   // ---------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_a_q      <= '0;
         r_b_q      <= '0;
         r_id_q     <= '0;
         r_rsp_p    <= '0;
         r_rsp_id   <= '0;
         r_op_count <= '0;
      end else begin
         r_state <= w_state_next;

         if (w_take) begin
            r_a_q  <= w_win_a;
            r_b_q  <= w_win_b;
            r_id_q <= w_win_idx;
            r_ptr  <= ring_inc(w_win_idx, N_REQ);
         end

         // Result register is loaded only from CALC, so it stays frozen
         // throughout RESP regardless of how long the consumer stalls.
         if (r_state == CALC) begin
            r_rsp_p  <= w_prod;
            r_rsp_id <= r_id_q;
         end

         if (w_done) begin
            r_op_count <= r_op_count + 1'b1;
         end
      end
   end

   assign rsp_valid = (r_state == RESP);
   assign rsp_p     = r_rsp_p;
   assign rsp_id    = r_rsp_id;
   assign op_count  = r_op_count;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
// Directed stimulus pushes hand-computed expected responses into a queue; an
// independent monitor pops and compares on every response handshake, and also
// checks grant one-hotness and result stability under backpressure.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [15:0] req_a = '0;
   logic [15:0] req_b = '0;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_p;
   logic [2:0]  rsp_id;
   logic        rsp_ready = 1'b1;
   logic [7:0]  op_count;

   mult_arbiter #(.N_REQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_p     (rsp_p),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] id;
      logic [7:0] p;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_fails  = 0;
   int         hs_count = 0;
   logic [7:0] exp_cnt  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------
   logic       prev_hold = 1'b0;
   logic [7:0] prev_p    = '0;
   logic [2:0] prev_id   = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_hold = 1'b0;
         exp_cnt   = '0;
      end else begin
         chk("grant_onehot", 32'($countones(req_ready) <= 1), 1);
         if (rsp_valid) chk("ready_while_busy", req_ready, 0);
         if (prev_hold) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_p", rsp_p, prev_p);
            chk("hold_id", rsp_id, prev_id);
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL unexpected_rsp: got id=%0d p=%0d, expected no response", rsp_id, rsp_p);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_p", rsp_p, e.p);
               chk("rsp_id", rsp_id, e.id);
               chk("op_count_pre", op_count, exp_cnt);
               $display("rsp: id=%0d p=%0d (expected id=%0d p=%0d) op_count=%0d",
                        rsp_id, rsp_p, e.id, e.p, op_count);
            end
            exp_cnt++;
            hs_count++;
         end
         prev_hold = rsp_valid && !rsp_ready;
         prev_p    = rsp_p;
         prev_id   = rsp_id;
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers (entered and left at posedge+1)
   // ---------------------------------------------------------------------
   task automatic push_exp(input int id, input logic [7:0] p);
      exp_t e;
      e.id = 3'(id);
      e.p  = p;
      exp_q.push_back(e);
   endtask

   // Waits for any grant; reports how many idle negedges passed first.
   task automatic wait_grant(input int idx, output int waited);
      bit got;
      got    = 1'b0;
      waited = 0;
      for (int c = 0; c < 16 && !got; c++) begin
         @(negedge clk);
         if (req_ready != 0) got = 1'b1;
         else waited++;
      end
      if (!got) begin
         n_checks++;
         n_fails++;
         $display("FAIL grant_timeout: req_ready=%b, expected grant to %0d", req_ready, idx);
      end else begin
         chk("grant", req_ready, 32'(1) << idx);
      end
   endtask

   task automatic wait_hs(input int target);
      for (int c = 0; c < 64; c++) begin
         @(posedge clk);
         if (hs_count >= target) break;
      end
      if (hs_count < target) begin
         n_checks++;
         n_fails++;
         $display("FAIL handshake_timeout: hs=%0d, expected %0d", hs_count, target);
      end
      #1;
   endtask

   task automatic single_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] p);
      int w;
      int target;
      target = hs_count + 1;
      req_a[idx*4 +: 4] = a;
      req_b[idx*4 +: 4] = b;
      req_valid[idx]    = 1'b1;
      wait_grant(idx, w);
      push_exp(idx, p);
      @(posedge clk); #1;
      req_valid[idx] = 1'b0;
      @(negedge clk); chk("lat_t1_valid", rsp_valid, 0);
      @(negedge clk); chk("lat_t2_valid", rsp_valid, 1);
      wait_hs(target);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------
   initial begin
      int w;
      int target;
      int order[5] = '{0, 1, 2, 3, 0};
      int prods[5] = '{25, 30, 35, 40, 25};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_p", rsp_p, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_idle_ready", req_ready, 0);
      @(posedge clk); #1;

      // Single request 3*2
      single_op(0, 4'd3, 4'd2, 8'd6);
      @(negedge clk); chk("single_op_count", op_count, 1);
      @(posedge clk); #1;

      // All four requesting continuously
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_a[i*4 +: 4] = 4'(i + 5);
         req_b[i*4 +: 4] = 4'd5;
      end
      req_valid = 4'hF;
      target = hs_count + 5;
      for (int k = 0; k < 5; k++) begin
         wait_grant(order[k], w);
         push_exp(order[k], 8'(prods[k]));
         chk("grant_gap", w, (k == 0) ? 0 : 2);
      end
      @(posedge clk); #1;
      req_valid = '0;
      wait_hs(target);

      // Backpressure: 15*15 on requester 2, requester 0 waiting behind it
      rsp_ready = 1'b0;
      req_a[11:8] = 4'd15;
      req_b[11:8] = 4'd15;
      req_valid = 4'b0100;
      target = hs_count + 1;
      wait_grant(2, w);
      push_exp(2, 8'd225);
      @(posedge clk); #1;
      req_valid = 4'b0001;
      req_a[3:0] = 4'd0;
      req_b[3:0] = 4'd10;
      @(negedge clk);
      @(negedge clk);
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk("stall_valid", rsp_valid, 1);
         chk("stall_ready", req_ready, 0);
         chk("stall_p", rsp_p, 225);
         chk("stall_id", rsp_id, 2);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_hs(target);

      // Requester 0 (0*10) gets the next grant once the pointer wraps
      target = hs_count + 1;
      wait_grant(0, w);
      push_exp(0, 8'd0);
      chk("bp_next_grant_immediate", w, 0);
      @(posedge clk); #1;
      req_valid = '0;
      wait_hs(target);

      single_op(3, 4'd7, 4'd1, 8'd7);

      // Reset while RESP is stalled: result discarded, pointer back to 0
      rsp_ready = 1'b0;
      req_a[11:8] = 4'd2;
      req_b[11:8] = 4'd3;
      req_valid = 4'b0100;
      wait_grant(2, w);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk); chk("pre_rst_valid", rsp_valid, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid = 4'b1010;
      req_a[7:4] = 4'd9;
      req_b[7:4] = 4'd9;
      @(negedge clk); chk("ready_during_rst", req_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      target = hs_count + 1;
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_op_count", op_count, 0);
      chk("post_rst_grant", req_ready, 4'b0010);
      push_exp(1, 8'd81);
      @(posedge clk); #1;
      req_valid = '0;
      wait_hs(target);

      // Exhaustive sweep on requester 1; 256 completions wrap the counter
      do_reset();
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            single_op(1, 4'(a), 4'(b), 8'(a * b));
         end
      end
      @(negedge clk); chk("op_count_wrap", op_count, 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, meaning number of requesters sharing one multiplier (2..8).
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  N_REQ  per-requester operation request.
REQ-005 req_a  input  4*N_REQ  multiplicand, requester i at bits [4i+3:4i].
REQ-006 req_b  input  4*N_REQ  multiplier, requester i at bits [4i+3:4i].
REQ-007 req_ready  output  N_REQ  one-hot grant; requester i's operands accepted when req_valid[i] and req_ready[i] are both high.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_p  output  8  unsigned product.
REQ-010 rsp_id  output  3  index of the requester that owns rsp_p.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 op_count  output  8  completed-response counter.

Function
REQ-013 FSM SHALL have three states: IDLE, CALC, RESP.
REQ-014 IDLE: if any req_valid is high, the round-robin winner's req_ready bit SHALL be high combinationally that cycle; at the edge, a_q/b_q/id_q capture the winner's operands and index; next state CALC.
REQ-015 IDLE with no req_valid: req_ready SHALL be all-zero; stay IDLE.
REQ-016 req_ready SHALL be all-zero in CALC and RESP, and at most one bit SHALL be high in any cycle.
REQ-017 Round-robin: search starts at index ptr and proceeds upward with wrap; after a grant to g, ptr SHALL become (g+1) mod N_REQ; ptr unchanged when no grant.
REQ-018 CALC: the 4x4 unsigned product of a_q*b_q SHALL be registered into rsp_p and id_q into rsp_id; next state RESP.
REQ-019 RESP: rsp_valid SHALL be high; rsp_p/rsp_id SHALL be held stable until rsp_ready.
REQ-020 RESP with rsp_ready high: at the edge, state goes IDLE, rsp_valid drops, and op_count increments by 1, wrapping 255->0.
REQ-021 Latency: grant in cycle t -> rsp_valid first high in cycle t+2; the next grant is possible no earlier than the cycle after the response handshake (single outstanding operation).
REQ-022 Product width: full 8 bits, no truncation; 15*15 = 225.
REQ-023 rsp_ready high outside RESP SHALL be ignored.
REQ-024 req_valid changes after a grant SHALL NOT affect the captured operation.

Reset
REQ-025 rst high at an edge SHALL force state IDLE, ptr=0, rsp_valid=0, rsp_p=0, rsp_id=0, op_count=0, a_q=b_q=id_q=0, regardless of current state.
REQ-026 Reset mid-operation (CALC or RESP) SHALL discard the in-flight result with no response and no op_count increment.
REQ-027 In the cycle rst is high, req_ready SHALL be all-zero.

Structure
REQ-028 State encoding (IDLE/CALC/RESP) and the operand width constant (4) SHALL live in a shared package, mult_pkg.
REQ-029 The product SHALL be computed by one instance of the existing multiplier_4x4 sub-module (ports A, B, P); no other multiplier logic.
REQ-030 Arbitration SHALL be inline; no separate arbiter module.

Verification
REQ-031 Single request: req 0 with A=3, B=2, rsp_ready tied high -> req_ready[0] high in cycle t, rsp_valid high in t+2 with rsp_p=6, rsp_id=0, op_count=1 afterward.
REQ-032 All four requesting continuously (i: A=i+5, B=5), rsp_ready high -> grant order 0,1,2,3,0; products 25,30,35,40,25.
REQ-033 Backpressure: req 2 with A=15, B=15, rsp_ready low for 5 cycles -> rsp_valid held, rsp_p=225, rsp_id=2 stable, no req_ready pulses until handshake.
REQ-034 Edge operands: A=0, B=10 -> 0; A=7, B=1 -> 7; exhaustive 256-pair sweep on requester 1 matches A*B.
REQ-035 Reset in RESP (rsp_ready low): rst for 1 cycle -> rsp_valid=0 next cycle, op_count=0, ptr=0, so the next grant goes to the lowest valid index.
REQ-036 Counter wrap: 256 completed operations -> op_count returns to 0.
